flopr_pipe: RTL and testbench
=============================

Name: flopr_pipe

Overview:
- Parametrised successor to the plain resettable flop: a chain of STAGES register stages carrying WIDTH-bit data under valid/ready flow control.
- Provides per-stage valid tracking, bubble collapsing, backpressure and synchronous flush.
- Used between datapath units, for example as a fetch/decode or memory-response pipeline register, where stalls and flushes must not lose or duplicate data.

Parameters:
- WIDTH, 32, data width in bits (>=1).
- STAGES, 2, number of register stages (1..8); this is the zero-stall latency in cycles.
- RESET_VAL, '0, data value loaded into every stage on reset.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-low reset (0 = reset asserted).
- flush  input  1  synchronous pipeline clear, active-high.
- in_valid  input  1  upstream has data.
- in_ready  output  1  stage 0 can accept this cycle.
- in_data  input  WIDTH  upstream data.
- out_valid  output  1  last stage holds valid data.
- out_ready  input  1  downstream accepts this cycle.
- out_data  output  WIDTH  last-stage data.
- occupancy  output  $clog2(STAGES+1)  number of valid stages.

Behaviour:
- State per stage i (0..STAGES-1): v[i] and d[i]. Stage STAGES-1 drives out_valid and out_data.
- Reset (reset==0, asynchronous, independent of clk):
  - All v[i]=0 and all d[i]=RESET_VAL, so out_valid=0, out_data=RESET_VAL, occupancy=0.
  - in_ready=0 while reset is asserted.
  - Release is taken on the next clk edge; the first accept is possible on the first edge with reset==1.
- Ready chain (combinational):
  - r[STAGES]=out_ready.
  - r[i] = !v[i] | r[i+1].
  - in_ready = r[0] & !flush & reset.
- Stage update on posedge clk when flush==0:
  - Stage 0: if r[0], then v[0] <= in_valid & in_ready and d[0] <= in_data. d[0] is loaded only when in_valid is high.
  - Stage i>0: if r[i], then v[i] <= v[i-1] and d[i] <= d[i-1]. d[i] is loaded only when v[i-1] is high.
  - If r[i]==0 the stage holds both v[i] and d[i].
- Bubble collapse: an empty stage fills even when downstream is stalled, so STAGES items can be buffered under a full stall.
- Handshakes:
  - Transfer in = in_valid & in_ready.
  - Transfer out = out_valid & out_ready.
  - Both may happen in the same cycle.
  - When the pipe is full and out_ready=1, in_ready=1 (full throughput).
- Stall stability: while out_valid=1 and out_ready=0, out_data and out_valid hold unchanged.
- Flush (posedge clk with flush==1):
  - All v[i] <= 0. Data registers hold their values and are not cleared.
  - in_ready=0 that cycle, so no input is captured.
  - Any output transfer that cycle (out_valid & out_ready) still counts as delivered.
  - Flush and reset together: reset dominates.
- out_data when out_valid==0: holds its last value (RESET_VAL after reset). This value is deterministic, but consumers must ignore it.
- occupancy = popcount(v); combinational from registers, ranges 0..STAGES.
- Ordering: items exit in acceptance order. No loss, no duplication.
- Latency:
  - An item accepted at edge n appears on out_valid/out_data after edge n+STAGES-1 (visible STAGES cycles after presentation), provided no stall occurs.
  - Each stall cycle adds one cycle.
- STAGES==1 degenerates to a single register with valid/ready (in_ready = !v[0] | out_ready).
- No combinational path from in_data to out_data. in_ready depends combinationally on out_ready (accepted; no skid buffer).

Test Plan:
- Reset/idle: WIDTH=32, STAGES=2, RESET_VAL=32'hDEAD_BEEF; hold reset=0 mid-cycle -> immediately out_valid=0, out_data=32'hDEAD_BEEF, occupancy=0, in_ready=0; release -> in_ready=1.
- Streaming: out_ready=1, send 32'h1234_5678, 32'hABCD_EF01, 32'h0000_0001 on consecutive cycles -> same values on out_data in order, first one 2 cycles after presentation, in_ready never drops.
- Full stall: out_ready=0, offer 3 items -> first 2 accepted, occupancy=2, in_ready=0, out_data=first item stable; raise out_ready -> items drain in order, third accepted the same cycle the first leaves.
- Bubble collapse: with STAGES=3 and only stage 2 valid and stalled, offer an item -> accepted, occupancy 1->2, lands in stage 1 next edge.
- Flush: pipe holding 2 items, pulse flush with in_valid=1 and in_data=32'hCAFE_F00D -> occupancy=0, out_valid=0 next cycle, 32'hCAFE_F00D never appears at the output.
- Async reset mid-stream: assert reset=0 between edges with 2 items in flight -> out_valid falls without a clock edge; after release the pipe is empty and no stale item is emitted.

Source files
------------

// File: rtl/flopr_pipe.sv
// flopr_pipe: STAGES-deep valid/ready register pipeline with bubble collapse, backpressure and flush
module flopr_pipe #(
  parameter int WIDTH = 32,
  parameter int STAGES = 2,
  parameter logic [WIDTH-1:0] RESET_VAL = '0,
  localparam int OW = $clog2(STAGES + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [OW-1:0]    occupancy
);
  logic [STAGES-1:0] v;
  logic [WIDTH-1:0]  d [STAGES];
  logic [STAGES:0]   r;
  // a stage may load when it is empty or its contents move on this cycle
  assign r[STAGES] = out_ready;
  for (genvar g = 0; g < STAGES; g++) begin : g_r
    assign r[g] = !v[g] | r[g+1];
  end
  assign in_ready  = r[0] & !flush & reset;
  assign out_valid = v[STAGES-1];
  assign out_data  = d[STAGES-1];
  always_comb begin
    occupancy = '0;
    for (int i = 0; i < STAGES; i++) occupancy = occupancy + OW'(v[i]);
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      v <= '0;
      for (int i = 0; i < STAGES; i++) d[i] <= RESET_VAL;
    end else if (flush) begin
      v <= '0;
    end else begin
      if (r[0]) begin
        v[0] <= in_valid & in_ready;
        if (in_valid) d[0] <= in_data;
      end
      for (int i = 1; i < STAGES; i++) begin
        if (r[i]) begin
          v[i] <= v[i-1];
          if (v[i-1]) d[i] <= d[i-1];
        end
      end
    end
  end
endmodule

// File: tb/tb_flopr_pipe.sv
// tb_flopr_pipe: vector table on a 2-stage pipe, directed and random model checks on a 3-stage pipe
module tb_flopr_pipe;
  localparam logic [31:0] RV = 32'hDEAD_BEEF;
  localparam int S3 = 3;
  logic clk = 0;
  always #5 clk = ~clk;
  logic reset = 1, flush = 0, in_valid = 0, out_ready = 0;
  logic [31:0] in_data = 0;
  logic in_ready, out_valid;
  logic [31:0] out_data;
  logic [1:0] occupancy;
  logic flush3 = 0, in_valid3 = 0, out_ready3 = 0;
  logic [31:0] in_data3 = 0;
  logic in_ready3, out_valid3;
  logic [31:0] out_data3;
  logic [1:0] occupancy3;
  int checks = 0, errors = 0;
  flopr_pipe #(.WIDTH(32), .STAGES(2), .RESET_VAL(RV)) u2 (
    .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .occupancy(occupancy)
  );
  flopr_pipe #(.WIDTH(32), .STAGES(S3)) u3 (
    .clk(clk), .reset(reset), .flush(flush3), .in_valid(in_valid3), .in_ready(in_ready3),
    .in_data(in_data3), .out_valid(out_valid3), .out_ready(out_ready3), .out_data(out_data3),
    .occupancy(occupancy3)
  );
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask
  typedef struct {
    logic iv; logic [31:0] id; logic ordy; logic fl;
    logic ir; logic ov; logic [31:0] od; int occ;
  } vec_t;
  vec_t tbl [17];
  // reference for the 3-stage pipe: items in acceptance order, each with its stage position
  logic [31:0] md[$];
  int mp[$];
  task automatic step3(input logic iv, input logic [31:0] id, input logic ordy, input logic fl);
    logic eir, eov, acc;
    int prev;
    in_valid3 = iv; in_data3 = id; out_ready3 = ordy; flush3 = fl;
    @(negedge clk);
    eir = reset && !fl && (md.size() < S3 || ordy);
    eov = md.size() > 0 && mp[0] == S3 - 1;
    acc = iv && eir;
    chk("m_in_ready", in_ready3, eir);
    chk("m_out_valid", out_valid3, eov);
    chk("m_occupancy", occupancy3, md.size());
    if (eov) chk("m_out_data", out_data3, md[0]);
    @(posedge clk);
    if (fl) begin
      md.delete(); mp.delete();
    end else begin
      if (eov && ordy) begin md.pop_front(); void'(mp.pop_front()); end
      prev = S3;
      for (int i = 0; i < mp.size(); i++) begin
        if (mp[i] + 1 < prev) mp[i]++;
        prev = mp[i];
      end
      if (acc) begin md.push_back(id); mp.push_back(0); end
    end
    #1;
  endtask
  initial begin
    tbl[0]  = '{1, 32'h1234_5678, 1, 0, 1, 0, RV, 0};
    tbl[1]  = '{1, 32'hABCD_EF01, 1, 0, 1, 0, RV, 1};
    tbl[2]  = '{1, 32'h0000_0001, 1, 0, 1, 1, 32'h1234_5678, 2};
    tbl[3]  = '{0, 32'h9999_9999, 1, 0, 1, 1, 32'hABCD_EF01, 2};
    tbl[4]  = '{0, 32'h9999_9999, 1, 0, 1, 1, 32'h0000_0001, 1};
    tbl[5]  = '{0, 32'h9999_9999, 1, 0, 1, 0, 32'h0000_0001, 0};
    tbl[6]  = '{1, 32'h1111_1111, 0, 0, 1, 0, 32'h0000_0001, 0};
    tbl[7]  = '{1, 32'h2222_2222, 0, 0, 1, 0, 32'h0000_0001, 1};
    tbl[8]  = '{1, 32'h3333_3333, 0, 0, 0, 1, 32'h1111_1111, 2};
    tbl[9]  = '{1, 32'h3333_3333, 0, 0, 0, 1, 32'h1111_1111, 2};
    tbl[10] = '{1, 32'h3333_3333, 1, 0, 1, 1, 32'h1111_1111, 2};
    tbl[11] = '{0, 32'h0, 1, 0, 1, 1, 32'h2222_2222, 2};
    tbl[12] = '{0, 32'h0, 0, 0, 1, 1, 32'h3333_3333, 1};
    tbl[13] = '{1, 32'h4444_4444, 0, 0, 1, 1, 32'h3333_3333, 1};
    tbl[14] = '{1, 32'hCAFE_F00D, 0, 1, 0, 1, 32'h3333_3333, 2};
    tbl[15] = '{0, 32'h0, 1, 0, 1, 0, 32'h3333_3333, 0};
    tbl[16] = '{0, 32'h0, 1, 0, 1, 0, 32'h3333_3333, 0};
    #3 reset = 0;
    #1;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data", out_data, RV);
    chk("rst_occupancy", occupancy, 0);
    chk("rst_in_ready", in_ready, 0);
    @(posedge clk); @(posedge clk); @(negedge clk);
    reset = 1;
    #1 chk("release_in_ready", in_ready, 1);
    @(posedge clk); #1;
    for (int k = 0; k < 17; k++) begin
      in_valid = tbl[k].iv; in_data = tbl[k].id; out_ready = tbl[k].ordy; flush = tbl[k].fl;
      @(negedge clk);
      chk($sformatf("v%0d_in_ready", k), in_ready, tbl[k].ir);
      chk($sformatf("v%0d_out_valid", k), out_valid, tbl[k].ov);
      chk($sformatf("v%0d_out_data", k), out_data, tbl[k].od);
      chk($sformatf("v%0d_occupancy", k), occupancy, tbl[k].occ);
      @(posedge clk); #1;
    end
    flush = 0; out_ready = 0; in_valid = 1; in_data = 32'h5555_5555;
    @(posedge clk); #1 in_data = 32'h6666_6666;
    @(posedge clk); #1 in_valid = 0;
    chk("mid_occ_before", occupancy, 2);
    #2 reset = 0;
    #1;
    chk("mid_out_valid", out_valid, 0);
    chk("mid_occupancy", occupancy, 0);
    chk("mid_out_data", out_data, RV);
    chk("mid_in_ready", in_ready, 0);
    #3 reset = 1;
    out_ready = 1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("post_rst_out_valid", out_valid, 0);
    end
    @(posedge clk); #1;
    step3(1, 32'hB0B0_0001, 0, 0);
    step3(0, 32'h0, 0, 0);
    step3(0, 32'h0, 0, 0);
    chk("bubble_occ1", occupancy3, 1);
    chk("bubble_valid", out_valid3, 1);
    step3(1, 32'hB0B0_0002, 0, 0);
    chk("bubble_occ2", occupancy3, 2);
    step3(0, 32'h0, 0, 0);
    step3(1, 32'hB0B0_0003, 0, 0);
    chk("bubble_full", occupancy3, 3);
    step3(1, 32'hB0B0_0004, 0, 0);
    chk("bubble_stall_data", out_data3, 32'hB0B0_0001);
    for (int k = 0; k < 5; k++) step3(0, 32'h0, 1, 0);
    for (int k = 0; k < 800; k++)
      step3($urandom_range(0, 9) < 7, $urandom, $urandom_range(0, 9) < 6, $urandom_range(0, 19) == 0);
    for (int k = 0; k < 5; k++) step3(0, 32'h0, 1, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
